// File: rtl/prng_checker.sv
// prng_checker: self-synchronising receive-side LFSR checker with flywheel lock, bit-error count and epoch flag
module prng_checker #(
  parameter int          OUT_BITS      = 4,
  parameter int          N_BITS_REGS   = 31,
  parameter logic [63:0] POLY          = 64'b1001000000000000000000000000000,
  parameter logic [63:0] INITIAL_STATE = 64'd1,
  parameter int          LOCK_CNT      = 4,
  parameter int          LOSS_THRESH   = 3,
  parameter int          CNT_BITS      = 16
) (
  input  logic                clk_in,
  input  logic                rst_in_n,
  input  logic                valid_in,
  input  logic [OUT_BITS-1:0] data_in,
  input  logic                clear_in,
  output logic                locked_out,
  output logic                err_out,
  output logic [CNT_BITS-1:0] err_cnt_out,
  output logic                sync_out
);
  localparam int N          = N_BITS_REGS;
  localparam int SEED_WORDS = (N + OUT_BITS - 1) / OUT_BITS;
  localparam int CW         = $clog2(SEED_WORDS + LOCK_CNT + LOSS_THRESH + 1);
  localparam int PW         = $clog2(OUT_BITS + 1);
  localparam int SUMW       = CNT_BITS + PW;
  localparam logic [N-1:0] TAPS    = POLY[N-1:0];
  localparam logic [N-1:0] EPOCH_ST = INITIAL_STATE[N-1:0];

  typedef enum logic [1:0] {SEED, ACQ, LOCKED} state_t;

  state_t              r_state, w_state;
  logic [N-1:0]        r_lfsr, w_lfsr;
  logic [CW-1:0]       r_seed, w_seed, r_good, w_good, r_bad, w_bad;
  logic [OUT_BITS-1:0] w_pred, w_diff;
  logic [PW-1:0]       w_pop;
  logic [SUMW-1:0]     w_sum;
  logic                w_err, w_sync;

  // Low N bits of {r, w}; also covers OUT_BITS == N where the word replaces the state
  function automatic logic [N-1:0] nxt(input logic [N-1:0] r, input logic [OUT_BITS-1:0] w);
    logic [N+OUT_BITS-1:0] t;
    t = {r, w};
    return t[N-1:0];
  endfunction

  always_comb begin
    w_pred = '0;
    w_pop  = '0;
    for (int i = 0; i < OUT_BITS; i++) w_pred[i] = ^(r_lfsr & (TAPS >> (OUT_BITS - 1 - i)));
    w_diff = data_in ^ w_pred;
    for (int i = 0; i < OUT_BITS; i++) w_pop = w_pop + PW'(w_diff[i]);
  end

  assign w_sum = SUMW'(err_cnt_out) + SUMW'(w_pop);

  always_comb begin
    w_state = r_state;
    w_lfsr  = r_lfsr;
    w_seed  = r_seed;
    w_good  = r_good;
    w_bad   = r_bad;
    w_err   = 1'b0;
    if (valid_in)
      case (r_state)
        SEED: begin
          w_lfsr = nxt(r_lfsr, data_in);
          w_seed = r_seed + CW'(1);
          if (r_seed == CW'(SEED_WORDS - 1)) begin
            w_state = ACQ;
            w_seed  = '0;
            w_good  = '0;
          end
        end
        ACQ: begin
          w_lfsr = nxt(r_lfsr, data_in);
          w_good = r_good + CW'(1);
          if (w_diff != '0) begin
            w_state = SEED;
            w_seed  = '0;
          end else if (r_good == CW'(LOCK_CNT - 1)) begin
            w_state = LOCKED;
            w_bad   = '0;
          end
        end
        LOCKED: begin
          // flywheel: received data never re-enters the register once locked
          w_lfsr = nxt(r_lfsr, w_pred);
          w_err  = w_diff != '0;
          w_bad  = w_err ? r_bad + CW'(1) : '0;
          if (w_err && r_bad == CW'(LOSS_THRESH - 1)) begin
            w_state = SEED;
            w_seed  = '0;
            w_bad   = '0;
          end
        end
        default: w_state = SEED;
      endcase
    w_sync = valid_in && r_state == LOCKED && w_lfsr == EPOCH_ST;
  end

  always_ff @(posedge clk_in or negedge rst_in_n)
    if (!rst_in_n) begin
      r_state     <= SEED;
      r_lfsr      <= '0;
      r_seed      <= '0;
      r_good      <= '0;
      r_bad       <= '0;
      locked_out  <= 1'b0;
      err_out     <= 1'b0;
      sync_out    <= 1'b0;
      err_cnt_out <= '0;
    end else begin
      r_state     <= w_state;
      r_lfsr      <= w_lfsr;
      r_seed      <= w_seed;
      r_good      <= w_good;
      r_bad       <= w_bad;
      locked_out  <= w_state == LOCKED;
      err_out     <= w_err;
      sync_out    <= w_sync;
      err_cnt_out <= clear_in ? '0 : !w_err ? err_cnt_out :
                     |w_sum[SUMW-1:CNT_BITS] ? '1 : w_sum[CNT_BITS-1:0];
    end
endmodule

// File: tb/tb_prng_checker.sv
// tb_prng_checker: serial-LFSR generator model feeding two checker configs through an XOR error mask
module tb_prng_checker;
  localparam logic [63:0] P0 = 64'h4800_0000;
  localparam logic [63:0] P1 = 64'h60;

  typedef struct {
    bit v; logic [3:0] mask; bit clr; bit locked; bit err; int cnt;
  } vec_t;
  typedef struct {
    bit locked; bit err; bit sync; int cnt; string tag;
  } exp_t;

  logic clk = 0, rst_n = 0;
  logic v0 = 0, c0 = 0, l0, e0, s0;
  logic [3:0] d0 = '0;
  logic [15:0] n0;
  logic v1 = 0, c1 = 0, l1, e1, s1;
  logic [0:0] d1 = '0;
  logic [3:0] n1;

  int errors = 0, checks = 0;
  logic [63:0] g0 = 64'd1, g1 = 64'd1;
  bit pl0 = 0, pl1 = 0;
  exp_t q[$];
  int sp[$];

  always #5 clk = ~clk;

  prng_checker u0 (
    .clk_in(clk), .rst_in_n(rst_n), .valid_in(v0), .data_in(d0), .clear_in(c0),
    .locked_out(l0), .err_out(e0), .err_cnt_out(n0), .sync_out(s0)
  );

  prng_checker #(
    .OUT_BITS(1), .N_BITS_REGS(7), .POLY(P1), .INITIAL_STATE(64'd1),
    .LOCK_CNT(4), .LOSS_THRESH(3), .CNT_BITS(4)
  ) u1 (
    .clk_in(clk), .rst_in_n(rst_n), .valid_in(v1), .data_in(d1), .clear_in(c1),
    .locked_out(l1), .err_out(e1), .err_cnt_out(n1), .sync_out(s1)
  );

  function automatic vec_t mk(bit v, logic [3:0] m, bit c, bit l, bit e, int n);
    vec_t t;
    t.v = v; t.mask = m; t.clr = c; t.locked = l; t.err = e; t.cnt = n;
    return t;
  endfunction

  // Bit-serial Fibonacci LFSR, oldest bit lands in the word MSB
  task automatic gen_step(input logic [63:0] s, input int n, input int ob, input logic [63:0] poly,
                          output logic [63:0] ns, output logic [63:0] w);
    logic [63:0] m;
    logic b;
    m = (64'd1 << n) - 64'd1;
    ns = s;
    w = '0;
    for (int k = 0; k < ob; k++) begin
      b = ^(ns & poly & m);
      ns = ((ns << 1) | {63'd0, b}) & m;
      w = (w << 1) | {63'd0, b};
    end
  endtask

  task automatic step(input int sel, input vec_t t, input string tag);
    logic [63:0] ns, w;
    logic [31:0] acnt;
    exp_t e, a;
    bit al, ae, as;
    e.locked = t.locked; e.err = t.err; e.cnt = t.cnt; e.sync = 0; e.tag = tag;
    if (sel == 0) begin
      v0 = t.v; c0 = t.clr;
      if (t.v) begin
        gen_step(g0, 31, 4, P0, ns, w);
        d0 = w[3:0] ^ t.mask;
        e.sync = pl0 && ns == 64'd1;
        g0 = ns;
      end
      pl0 = t.locked;
    end else begin
      v1 = t.v; c1 = t.clr;
      if (t.v) begin
        gen_step(g1, 7, 1, P1, ns, w);
        d1 = w[0:0] ^ t.mask[0:0];
        e.sync = pl1 && ns == 64'd1;
        g1 = ns;
      end
      pl1 = t.locked;
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    a = q.pop_front();
    al = sel != 0 ? l1 : l0;
    ae = sel != 0 ? e1 : e0;
    as = sel != 0 ? s1 : s0;
    acnt = sel != 0 ? 32'(n1) : 32'(n0);
    checks++;
    if (al !== a.locked || ae !== a.err || as !== a.sync || acnt !== 32'(a.cnt)) begin
      errors++;
      $display("FAIL %s: got locked=%0b err=%0b sync=%0b cnt=%0d, want locked=%0b err=%0b sync=%0b cnt=%0d",
               a.tag, al, ae, as, acnt, a.locked, a.err, a.sync, a.cnt);
    end
    v0 = 0; c0 = 0; v1 = 0; c1 = 0;
  endtask

  task automatic check_zero(input string tag);
    checks++;
    if ({l0, e0, s0, n0} !== '0) begin
      errors++;
      $display("FAIL %s dflt: got locked=%0b err=%0b sync=%0b cnt=%0d, want all 0", tag, l0, e0, s0, n0);
    end
    checks++;
    if ({l1, e1, s1, n1} !== '0) begin
      errors++;
      $display("FAIL %s small: got locked=%0b err=%0b sync=%0b cnt=%0d, want all 0", tag, l1, e1, s1, n1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    int ec, vw;
    tbl.push_back(mk(1, 4'b0000, 0, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 1, 0, 0));
    tbl.push_back(mk(1, 4'b0110, 0, 1, 1, 2));
    tbl.push_back(mk(1, 4'b0000, 0, 1, 0, 2));
    tbl.push_back(mk(0, 4'b1111, 0, 1, 0, 2));
    tbl.push_back(mk(1, 4'b0000, 0, 1, 0, 2));
    tbl.push_back(mk(1, 4'b0001, 0, 1, 1, 3));
    tbl.push_back(mk(1, 4'b0010, 0, 1, 1, 4));
    tbl.push_back(mk(1, 4'b1000, 0, 0, 1, 5));

    repeat (2) @(posedge clk);
    #2 check_zero("reset");
    rst_n = 1;

    for (int k = 1; k <= 15; k++) step(0, mk(1, 4'b0, 0, k >= 12, 0, 0), "t1_lock");
    foreach (tbl[i]) step(0, tbl[i], $sformatf("t3_tbl%0d", i));
    for (int k = 1; k <= 14; k++) step(0, mk(1, 4'b0, 0, k >= 12, 0, 5), "t4_relock");

    for (int k = 1; k <= 400; k++) begin
      step(1, mk(1, 4'b0, 0, k >= 11, 0, 0), "t2_run");
      if (s1 === 1'b1) sp.push_back(k);
    end
    checks++;
    if (sp.size() != 3) begin
      errors++;
      $display("FAIL t2_pulses: got %0d sync pulses, want 3", sp.size());
    end
    for (int i = 1; i < sp.size(); i++) begin
      checks++;
      if (sp[i] - sp[i-1] != 127) begin
        errors++;
        $display("FAIL t2_spacing: got %0d words between pulses, want 127", sp[i] - sp[i-1]);
      end
    end

    ec = 0;
    for (int j = 1; j <= 20; j++) begin
      ec = ec < 15 ? ec + 1 : 15;
      step(1, mk(1, 4'b1, 0, 1, 1, ec), "t5_inject");
      step(1, mk(1, 4'b0, 0, 1, 0, ec), "t5_clean");
      step(1, mk(1, 4'b0, 0, 1, 0, ec), "t5_clean");
    end
    step(1, mk(1, 4'b1, 1, 1, 1, 0), "t5_clr_wins");
    step(1, mk(1, 4'b1, 0, 1, 1, 1), "t5_after_clr");
    step(1, mk(0, 4'b0, 1, 1, 0, 0), "t5_clear_idle");
    step(1, mk(1, 4'b0, 0, 1, 0, 0), "t5_post");

    step(0, mk(0, 4'b0, 0, 1, 0, 5), "t6_gap");
    step(0, mk(1, 4'b0, 0, 1, 0, 5), "t6_pre");
    #2 rst_n = 0;
    #1 check_zero("t6_async");
    pl0 = 0; pl1 = 0;
    #2 rst_n = 1;
    vw = 0;
    for (int i = 0; i < 24; i++) begin
      bit vv;
      vv = (i % 3) != 2;
      if (vv) vw++;
      step(0, mk(vv, 4'b0, 0, vw >= 12, 0, 0), "t6_reacq");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
